// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared types and helpers for the Viterbi decoder
package viterbi_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fsm_t;

    // Number of trellis states for constraint length k
    function automatic int ns_of(input int k);
        return 1 << (k - 1);
    endfunction

    // Starting metric for every state other than the all-zero state
    function automatic int pm_init_of(input int pm_w);
        return 1 << (pm_w - 2);
    endfunction

    function automatic logic parity(input logic [7:0] v);
        return ^v;
    endfunction

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[1]} + {1'b0, v[0]};
    endfunction

endpackage

// File: rtl/viterbi_acs_unit.sv
// rtl/viterbi_acs_unit.sv - add-compare-select for one trellis state
module viterbi_acs_unit
    import viterbi_pkg::*;
#(
    parameter int PM_W = 6
) (
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  logic [1:0]      bm0,
    input  logic [1:0]      bm1,
    output logic [PM_W-1:0] pm_out,
    output logic            sel
);

    logic [PM_W-1:0] sum0;
    logic [PM_W-1:0] sum1;

    // Candidate metrics from both predecessors; ties favour predecessor 0
    always_comb begin
        sum0   = pm0 + {{(PM_W-2){1'b0}}, bm0};
        sum1   = pm1 + {{(PM_W-2){1'b0}}, bm1};
        sel    = (sum1 < sum0);
        pm_out = sel ? sum1 : sum0;
    end

endmodule

// File: rtl/viterbi_decoder_param.sv
// rtl/viterbi_decoder_param.sv - hard-decision rate-1/2 Viterbi decoder, register exchange
module viterbi_decoder_param
    import viterbi_pkg::*;
#(
    parameter int          K        = 3,
    parameter int unsigned G0       = 'o7,
    parameter int unsigned G1       = 'o5,
    parameter int          TB_DEPTH = 15,
    parameter int          PM_W     = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_sym,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_bit,
    output logic       out_last
);

    localparam int              NS       = ns_of(K);
    localparam int              SW       = K - 1;
    localparam int              CW       = $clog2(TB_DEPTH + 1);
    localparam logic [K-1:0]    G0_V     = K'(G0);
    localparam logic [K-1:0]    G1_V     = K'(G1);
    localparam logic [PM_W-1:0] PM_INIT  = PM_W'(pm_init_of(PM_W));
    localparam logic [CW-1:0]   CNT_FULL = CW'(TB_DEPTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TB_DEPTH - 1);

    fsm_t                fsm_q, fsm_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PM_W-1:0]     pm_q [NS];
    logic [PM_W-1:0]     pm_d [NS];
    logic [TB_DEPTH-1:0] hist_q [NS];
    logic [TB_DEPTH-1:0] hist_d [NS];
    logic                out_valid_q, out_valid_d;
    logic                out_bit_q, out_bit_d;
    logic                out_last_q, out_last_d;

    logic [PM_W-1:0]     pm_acs [NS];
    logic [PM_W-1:0]     pm_norm [NS];
    logic [PM_W-1:0]     am_in [NS];
    logic [TB_DEPTH-1:0] hist_new [NS];
    logic [TB_DEPTH-1:0] hb;
    logic [NS-1:0]       sel;
    logic [NS-1:0]       msb;
    logic [NS-1:0]       shout;
    logic [SW-1:0]       best;
    logic                drain_bit;
    logic                xfer;

    // Per-state branch metrics, ACS and survivor extension; predecessors are {n[K-3:0], b}
    for (genvar n = 0; n < NS; n++) begin : g_state
        localparam int           P0  = (2 * n) % NS;
        localparam int           P1  = (2 * n + 1) % NS;
        localparam logic [K-1:0] R0  = K'(2 * n);
        localparam logic [K-1:0] R1  = K'(2 * n + 1);
        localparam logic [1:0]   C0  = {parity(8'(G0_V & R0)), parity(8'(G1_V & R0))};
        localparam logic [1:0]   C1  = {parity(8'(G0_V & R1)), parity(8'(G1_V & R1))};
        localparam logic         DEC = R0[K-1];

        logic [1:0] bm0;
        logic [1:0] bm1;

        assign bm0 = popcount2(in_sym ^ C0);
        assign bm1 = popcount2(in_sym ^ C1);

        viterbi_acs_unit #(.PM_W(PM_W)) u_acs (
            .pm0    (pm_q[P0]),
            .pm1    (pm_q[P1]),
            .bm0    (bm0),
            .bm1    (bm1),
            .pm_out (pm_acs[n]),
            .sel    (sel[n])
        );

        assign msb[n]      = pm_acs[n][PM_W-1];
        assign hist_new[n] = sel[n] ? {hist_q[P1][TB_DEPTH-2:0], DEC}
                                    : {hist_q[P0][TB_DEPTH-2:0], DEC};
        assign shout[n]    = sel[n] ? hist_q[P1][TB_DEPTH-1] : hist_q[P0][TB_DEPTH-1];
    end

    // Normalise by dropping the MSB once every metric has crossed it
    always_comb begin
        for (int n = 0; n < NS; n++) begin
            pm_norm[n] = pm_acs[n];
            if (&msb) begin
                pm_norm[n][PM_W-1] = 1'b0;
            end
        end
    end

    // Best state: new metrics while decoding, frozen metrics while draining
    always_comb begin
        for (int n = 0; n < NS; n++) begin
            am_in[n] = (fsm_q == DRAIN) ? pm_q[n] : pm_norm[n];
        end
        best = '0;
        for (int n = 1; n < NS; n++) begin
            if (am_in[n] < am_in[best]) begin
                best = SW'(n);
            end
        end
    end

    // Drain picks survivor bit cnt-1 of the frozen best state
    always_comb begin
        hb        = hist_q[best];
        drain_bit = 1'b0;
        for (int i = 0; i < TB_DEPTH; i++) begin
            if (cnt_q == CW'(i + 1)) begin
                drain_bit = hb[i];
            end
        end
    end

    assign in_ready = rst_n && (fsm_q != DRAIN) && (!out_valid_q || out_ready);
    assign xfer     = in_valid && in_ready;

    // Next-state: frame FSM, metric/survivor update and output register
    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        pm_d        = pm_q;
        hist_d      = hist_q;
        out_valid_d = out_valid_q;
        out_bit_d   = out_bit_q;
        out_last_d  = out_last_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_bit_d   = 1'b0;
            out_last_d  = 1'b0;
        end

        case (fsm_q)
            FILL, RUN: begin
                if (xfer) begin
                    pm_d   = pm_norm;
                    hist_d = hist_new;
                    if (fsm_q == RUN) begin
                        out_valid_d = 1'b1;
                        out_bit_d   = shout[best];
                        out_last_d  = 1'b0;
                    end
                    if (in_last) begin
                        fsm_d = DRAIN;
                        cnt_d = (fsm_q == RUN) ? CNT_FULL : cnt_q + 1'b1;
                    end else if (fsm_q == FILL) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            fsm_d = RUN;
                        end
                    end
                end
            end
            default: begin
                if (out_valid_q && out_ready && out_last_q) begin
                    fsm_d = FILL;
                    cnt_d = '0;
                    for (int n = 0; n < NS; n++) begin
                        pm_d[n]   = (n == 0) ? '0 : PM_INIT;
                        hist_d[n] = '0;
                    end
                end else if ((cnt_q != '0) && (!out_valid_q || out_ready)) begin
                    out_valid_d = 1'b1;
                    out_bit_d   = drain_bit;
                    out_last_d  = (cnt_q == CW'(1));
                    cnt_d       = cnt_q - 1'b1;
                end
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q       <= FILL;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
            for (int n = 0; n < NS; n++) begin
                pm_q[n]   <= (n == 0) ? '0 : PM_INIT;
                hist_q[n] <= '0;
            end
        end else begin
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_last_q  <= out_last_d;
            pm_q        <= pm_d;
            hist_q      <= hist_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_viterbi_decoder_param.sv
// tb/tb_viterbi_decoder_param.sv - scoreboard bench for viterbi_decoder_param
module tb_viterbi_decoder_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_sym = 2'b00;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_bit;
    logic       out_last;

    always #5 clk = ~clk;

    viterbi_decoder_param #(
        .K(3), .G0('o7), .G1('o5), .TB_DEPTH(15), .PM_W(6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sym    (in_sym),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_last  (out_last)
    );

    int         n_pass = 0;
    int         n_chk = 0;
    bit         exp_q[$];
    bit         expl_q[$];
    logic [1:0] stim_q[$];
    bit         ref_q[$];
    bit         sb_on = 1'b0;
    bit         rand_ready = 1'b0;
    logic [1:0] enc_s = 2'b00;

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    // Sink handshake driver, changes just after each rising edge
    always begin
        @(posedge clk);
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops the scoreboard on each output handshake and checks stall stability
    bit prev_stall = 1'b0;
    bit prev_bit = 1'b0;
    bit prev_last = 1'b0;
    always @(negedge clk) begin
        bit eb, el;
        if (rst_n && sb_on) begin
            if (prev_stall) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_bit", int'(out_bit), int'(prev_bit));
                check("stall_last", int'(out_last), int'(prev_last));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    eb = exp_q.pop_front();
                    el = expl_q.pop_front();
                    check("out_bit", int'(out_bit), int'(eb));
                    check("out_last", int'(out_last), int'(el));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_bit   = out_bit;
            prev_last  = out_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send_sym(input logic [1:0] s, input logic last);
        int  waitc = 0;
        bit  acc = 1'b0;
        in_valid = 1'b1;
        in_sym   = s;
        in_last  = last;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            waitc++;
        end while (!acc && waitc < 1000);
        if (!acc) check("in_ready_timeout", 0, 1);
        #2;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic encode(input bit u, output logic [1:0] s);
        logic [2:0] r;
        r     = {u, enc_s};
        s     = {^(r & 3'b111), ^(r & 3'b101)};
        enc_s = {u, enc_s[1]};
    endtask

    // Directed frame: stim_q symbols, ref_q hand-computed decoded bits
    task automatic run_directed();
        for (int i = 0; i < ref_q.size(); i++) begin
            exp_q.push_back(ref_q[i]);
            expl_q.push_back(i == ref_q.size() - 1);
        end
        for (int i = 0; i < stim_q.size(); i++) begin
            send_sym(stim_q[i], i == stim_q.size() - 1);
        end
    endtask

    // Error-free random frame: decoded bits equal the information bits
    task automatic run_random(input int nbits, input bit push);
        logic [1:0] s;
        bit         u;
        enc_s = 2'b00;
        for (int i = 0; i < nbits; i++) begin
            u = 1'($urandom_range(0, 1));
            encode(u, s);
            if (push) begin
                exp_q.push_back(u);
                expl_q.push_back(i == nbits - 1);
            end
            send_sym(s, push && (i == nbits - 1));
        end
    endtask

    task automatic wait_drain(input string name);
        int c = 0;
        while (exp_q.size() != 0 && c < 3000) begin
            @(posedge clk);
            c++;
        end
        check(name, exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_bit", int'(out_bit), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_in_ready", int'(in_ready), 0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", int'(in_ready), 1);
        #1;
        sb_on = 1'b1;

        stim_q = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        ref_q  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        run_directed();
        wait_drain("drain_frame_a");

        stim_q = '{2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11};
        run_directed();
        wait_drain("drain_frame_err");

        stim_q = '{2'b11};
        ref_q  = '{1'b1};
        run_directed();
        wait_drain("drain_single");

        stim_q = '{2'b11, 2'b01, 2'b01, 2'b00};
        ref_q  = '{1'b1, 1'b1, 1'b0, 1'b1};
        run_directed();
        wait_drain("drain_four");

        run_random(200, 1'b1);
        wait_drain("drain_rand_ready1");

        rand_ready = 1'b1;
        run_random(200, 1'b1);
        wait_drain("drain_rand_stall");
        stim_q = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        ref_q  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        run_directed();
        wait_drain("drain_frame_a_stall");
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        sb_on = 1'b0;
        run_random(30, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrun_rst_out_valid", int'(out_valid), 0);
        check("midrun_rst_out_last", int'(out_last), 0);
        check("midrun_rst_in_ready", int'(in_ready), 0);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        expl_q.delete();
        @(posedge clk);
        #2;
        sb_on = 1'b1;
        run_directed();
        wait_drain("drain_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
